// File: rtl/point_log_solver.sv
// point_log_solver -- discrete-log search engine for the GF(2^7) test curve.
//
// The solver finds the smallest k in 0..MAX_K with k*P == Q. It walks the
// multiples O, P, 2P, 3P, ... The first doubling uses point_double. Every
// later step uses point_adder(acc, P).
//
// Curve:  y^2 + x*y = x^3 + a*x^2 + b over GF(2^7), with a = b = 1.
// Field:  the field polynomial is x^7 + x + 1.
// Encoding: a point is {x[6:0], y[6:0]}. The value 14'h0 stands for O. The
// pair (0,0) is not on the curve because b != 0, so this encoding is
// unambiguous.
//
// Ports (point_log_solver):
//   clk     clock; all logic is on posedge
//   reset   synchronous, active-high reset
//   start   begin a new search; samples base/target in this cycle
//   base    P = {x, y}; 14'h0 is the point at infinity
//   target  Q, same encoding
//   busy    a search is in progress
//   done    the result is valid; held until the next start or reset
//   found   1 means scalar is valid; 0 means Q is not in <P> within 0..MAX_K
//   scalar  smallest k with k*P == Q, or the last k examined

package point_log_gf_pkg;

  localparam logic [7:0] GF_POLY = 8'h83;   // x^7 + x + 1
  localparam logic [6:0] CURVE_A = 7'h01;

  function automatic logic [6:0] gf_mul(input logic [6:0] a, input logic [6:0] b);
    logic [12:0] prod;
    prod = '0;
    for (int i = 0; i < 7; i++)
      if (b[i]) prod = prod ^ ({6'b0, a} << i);
    for (int i = 12; i >= 7; i--)
      if (prod[i]) prod = prod ^ ({5'b0, GF_POLY} << (i - 7));
    return prod[6:0];
  endfunction

  function automatic logic [6:0] gf_sq(input logic [6:0] a);
    return gf_mul(a, a);
  endfunction

  // Compute a^-1 as a^126. This uses the addition chain 1,3,7,15,31,63,126.
  // The result for 0 is 0, and callers never rely on that value.
  function automatic logic [6:0] gf_inv(input logic [6:0] a);
    logic [6:0] a3, a7, a15, a31, a63;
    a3  = gf_mul(gf_sq(a), a);
    a7  = gf_mul(gf_sq(a3), a);
    a15 = gf_mul(gf_sq(a7), a);
    a31 = gf_mul(gf_sq(a15), a);
    a63 = gf_mul(gf_sq(a31), a);
    return gf_sq(a63);
  endfunction

  // Chord addition for points with distinct x. When the x values are equal,
  // the caller wanted either a doubling or P + (-P). In both cases this
  // returns O.
  function automatic logic [13:0] ec_add(input logic [13:0] p, input logic [13:0] q);
    logic [6:0] x1, y1, x2, y2, lam, x3, y3;
    x1 = p[13:7];
    y1 = p[6:0];
    x2 = q[13:7];
    y2 = q[6:0];
    if (p == '0) return q;
    if (q == '0) return p;
    if (x1 == x2) return '0;
    lam = gf_mul(y1 ^ y2, gf_inv(x1 ^ x2));
    x3  = gf_sq(lam) ^ lam ^ x1 ^ x2 ^ CURVE_A;
    y3  = gf_mul(lam, x1 ^ x3) ^ x3 ^ y1;
    return {x3, y3};
  endfunction

  // Tangent doubling. A point with x == 0 is its own negative, so 2P = O.
  function automatic logic [13:0] ec_double(input logic [13:0] p);
    logic [6:0] x1, y1, lam, x3, y3;
    x1 = p[13:7];
    y1 = p[6:0];
    if (x1 == '0) return '0;
    lam = x1 ^ gf_mul(y1, gf_inv(x1));
    x3  = gf_sq(lam) ^ lam ^ CURVE_A;
    y3  = gf_sq(x1) ^ gf_mul(lam ^ 7'h01, x3);
    return {x3, y3};
  endfunction

endpackage

// point_adder: captures its operands on start. The sum appears on 'sum'
// LATENCY cycles after the start pulse and is held until the next start.
module point_adder #(
  parameter int LATENCY = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] p1,
  input  logic [13:0] p2,
  output logic [13:0] sum
);
  localparam int CNT_W = $clog2(LATENCY);

  logic [13:0]      a_reg, b_reg, res_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             run_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      cnt_reg <= '0;
      run_reg <= 1'b0;
    end else if (start) begin
      a_reg   <= p1;
      b_reg   <= p2;
      cnt_reg <= CNT_W'(LATENCY - 1);
      run_reg <= 1'b1;
    end else if (run_reg) begin
      if (cnt_reg == CNT_W'(1)) begin
        res_reg <= point_log_gf_pkg::ec_add(a_reg, b_reg);
        run_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end
  end

  assign sum = res_reg;
endmodule

// point_double: has the same timing contract as point_adder, with one operand.
module point_double #(
  parameter int LATENCY = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] p,
  output logic [13:0] dbl
);
  localparam int CNT_W = $clog2(LATENCY);

  logic [13:0]      a_reg, res_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             run_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg   <= '0;
      res_reg <= '0;
      cnt_reg <= '0;
      run_reg <= 1'b0;
    end else if (start) begin
      a_reg   <= p;
      cnt_reg <= CNT_W'(LATENCY - 1);
      run_reg <= 1'b1;
    end else if (run_reg) begin
      if (cnt_reg == CNT_W'(1)) begin
        res_reg <= point_log_gf_pkg::ec_double(a_reg);
        run_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end
  end

  assign dbl = res_reg;
endmodule

module point_log_solver #(
  parameter int ADD_LATENCY = 31,
  parameter int MAX_K       = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] base,
  input  logic [13:0] target,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [6:0]  scalar
);
  localparam int WAIT_W = $clog2(ADD_LATENCY);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ADD_LATENCY - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]        state_reg;
  logic [13:0]       p_reg, q_reg, acc_reg;
  logic [6:0]        k_reg, scalar_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              use_dbl_reg, busy_reg, done_reg, found_reg;

  logic              add_start, dbl_start;
  logic [13:0]       add_sum, dbl_out;

  // The units see only the registered acc and P. These values do not change
  // from LAUNCH until the end of WAIT.
  assign add_start = (state_reg == S_LAUNCH) && !use_dbl_reg;
  assign dbl_start = (state_reg == S_LAUNCH) &&  use_dbl_reg;

  point_adder #(.LATENCY(ADD_LATENCY)) u_add (
    .clk   (clk),
    .reset (reset),
    .start (add_start),
    .p1    (acc_reg),
    .p2    (p_reg),
    .sum   (add_sum)
  );

  point_double #(.LATENCY(ADD_LATENCY)) u_dbl (
    .clk   (clk),
    .reset (reset),
    .start (dbl_start),
    .p     (acc_reg),
    .dbl   (dbl_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      p_reg        <= '0;
      q_reg        <= '0;
      acc_reg      <= '0;
      k_reg        <= '0;
      scalar_reg   <= '0;
      wait_cnt_reg <= '0;
      use_dbl_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      found_reg    <= 1'b0;
    end else if (start) begin
      // A start in any state abandons the current search. A unit that is
      // still counting is harmless: the next LAUNCH reloads it.
      state_reg    <= S_CHECK;
      p_reg        <= base;
      q_reg        <= target;
      acc_reg      <= '0;
      k_reg        <= '0;
      wait_cnt_reg <= '0;
      busy_reg     <= 1'b1;
      done_reg     <= 1'b0;
      found_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_CHECK: begin
          if (acc_reg == q_reg) begin
            found_reg  <= 1'b1;
            scalar_reg <= k_reg;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= S_FINISH;
          end else if (k_reg == 7'(MAX_K)) begin
            // Test against MAX_K before any increment, so k never wraps.
            scalar_reg <= k_reg;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= S_FINISH;
          end else if (acc_reg == '0) begin
            // O + P = P, so no unit is needed for this step.
            acc_reg <= p_reg;
            k_reg   <= k_reg + 7'd1;
          end else if (acc_reg == p_reg && p_reg[13:7] == '0) begin
            // For P with x == 0, P is its own negative and the order is 2.
            scalar_reg <= k_reg;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= S_FINISH;
          end else if (acc_reg == p_reg) begin
            use_dbl_reg <= 1'b1;
            state_reg   <= S_LAUNCH;
          end else if (acc_reg[13:7] == p_reg[13:7]) begin
            // Same x but a different point means acc == -P. The next multiple
            // would be O, so the whole cyclic group has been walked.
            scalar_reg <= k_reg;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= S_FINISH;
          end else begin
            use_dbl_reg <= 1'b0;
            state_reg   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wait_cnt_reg <= '0;
          state_reg    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_reg == WAIT_LAST) begin
            acc_reg   <= use_dbl_reg ? dbl_out : add_sum;
            k_reg     <= k_reg + 7'd1;
            state_reg <= S_CHECK;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          end
        end
        S_IDLE, S_FINISH: state_reg <= state_reg;
        default:          state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign found  = found_reg;
  assign scalar = scalar_reg;
endmodule

// File: tb/tb_point_log_solver.sv
`timescale 1ns/1ps
module tb_point_log_solver;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] base = '0;
  logic [13:0] target = '0;
  logic        busy, done, found;
  logic [6:0]  scalar;

  int checks = 0;
  int errors = 0;
  int launch_total = 0;
  logic [13:0] pts[$];

  always #5 clk = ~clk;

  point_log_solver dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .base   (base),
    .target (target),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .scalar (scalar)
  );

  always @(posedge clk)
    if (dut.add_start || dut.dbl_start) launch_total++;

  // ---------------- reference model: group law on y^2+xy=x^3+x^2+1 ----------------
  function automatic logic [6:0] fmul(input logic [6:0] a, input logic [6:0] b);
    logic [6:0] r, aa, bb;
    r = '0; aa = a; bb = b;
    for (int i = 0; i < 7; i++) begin
      if (bb[0]) r = r ^ aa;
      bb = bb >> 1;
      aa = aa[6] ? ((aa << 1) ^ 7'h03) : (aa << 1);
    end
    return r;
  endfunction

  function automatic logic [6:0] finv(input logic [6:0] a);
    for (int b = 1; b < 128; b++)
      if (fmul(a, 7'(b)) == 7'h01) return 7'(b);
    return 7'h00;
  endfunction

  function automatic bit on_curve(input logic [6:0] x, input logic [6:0] y);
    return (fmul(y, y) ^ fmul(x, y)) == (fmul(fmul(x, x), x) ^ fmul(x, x) ^ 7'h01);
  endfunction

  function automatic logic [13:0] padd(input logic [13:0] p, input logic [13:0] q);
    logic [6:0] x1, y1, x2, y2, l, x3, y3;
    if (p == 14'h0) return q;
    if (q == 14'h0) return p;
    x1 = p[13:7]; y1 = p[6:0]; x2 = q[13:7]; y2 = q[6:0];
    if (x1 == x2) begin
      if (y1 != y2 || x1 == 7'h0) return 14'h0;
      l  = x1 ^ fmul(y1, finv(x1));
      x3 = fmul(l, l) ^ l ^ 7'h01;
      y3 = fmul(x1, x1) ^ fmul(l ^ 7'h01, x3);
    end else begin
      l  = fmul(y1 ^ y2, finv(x1 ^ x2));
      x3 = fmul(l, l) ^ l ^ x1 ^ x2 ^ 7'h01;
      y3 = fmul(l, x1 ^ x3) ^ x3 ^ y1;
    end
    return {x3, y3};
  endfunction

  function automatic logic [13:0] pmul(input logic [13:0] p, input int k);
    logic [13:0] r;
    r = 14'h0;
    for (int i = 0; i < k; i++) r = padd(r, p);
    return r;
  endfunction

  // Walk O, P, 2P, ... and stop at Q, at k=127, or when the next multiple is O.
  task automatic ref_search(input logic [13:0] p, input logic [13:0] q,
                            output bit f, output int k);
    logic [13:0] m, nm;
    bit stop;
    m = 14'h0; k = 0; f = 1'b0; stop = 1'b0;
    while (!stop) begin
      nm = padd(m, p);
      if (m == q) begin
        f = 1'b1; stop = 1'b1;
      end else if (k == 127) begin
        stop = 1'b1;
      end else if (nm == 14'h0 && m != 14'h0) begin
        stop = 1'b1;
      end else begin
        m = nm; k++;
      end
    end
  endtask

  // Cycles from start to done. The O steps take 1 cycle each. Each unit step
  // costs CHECK + LAUNCH + 31 wait cycles.
  function automatic int exp_cycles(input logic [13:0] p, input int k);
    if (p == 14'h0) return 2 + k;
    if (k == 0) return 2;
    return 3 + (k - 1) * 33;
  endfunction

  function automatic logic [13:0] rand_pt();
    return pts[$urandom_range(0, pts.size() - 1)];
  endfunction

  // ---------------- stimulus ----------------
  task automatic run_search(input logic [13:0] b, input logic [13:0] t, output int cyc);
    base = b; target = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    $display("search P=%h Q=%h -> done=%0d found=%0d scalar=%0d cycles=%0d",
             b, t, done, found, scalar, cyc);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; base = pts[0]; target = 14'h0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (found !== 1'b0)   begin errors++; $display("FAIL reset_found got %b want 0", found); end
    checks++; if (scalar !== 7'd0)  begin errors++; $display("FAIL reset_scalar got %0d want 0", scalar); end
    reset = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_zero_target();
    int cyc;
    logic [13:0] p;
    for (int i = 0; i < 3; i++) begin
      p = rand_pt();
      run_search(p, 14'h0, cyc);
      checks++; if (found !== 1'b1)  begin errors++; $display("FAIL zero_found got %b want 1", found); end
      checks++; if (scalar !== 7'd0) begin errors++; $display("FAIL zero_scalar got %0d want 0", scalar); end
      checks++; if (cyc != 2)        begin errors++; $display("FAIL zero_cycles got %0d want 2", cyc); end
    end
  endtask

  task automatic test_self();
    int cyc, l0;
    logic [13:0] p;
    for (int i = 0; i < 3; i++) begin
      p = rand_pt();
      l0 = launch_total;
      run_search(p, p, cyc);
      checks++; if (found !== 1'b1)  begin errors++; $display("FAIL self_found got %b want 1", found); end
      checks++; if (scalar !== 7'd1) begin errors++; $display("FAIL self_scalar got %0d want 1", scalar); end
      checks++; if (cyc != 3)        begin errors++; $display("FAIL self_cycles got %0d want 3", cyc); end
      checks++; if (launch_total != l0) begin
        errors++; $display("FAIL self_launches got %0d want 0", launch_total - l0);
      end
    end
  endtask

  task automatic test_round_trip();
    int ks[6];
    int cyc, ek;
    bit ef;
    logic [13:0] p, q;
    ks[0] = 2; ks[1] = 5; ks[2] = 37;
    for (int i = 3; i < 6; i++) ks[i] = $urandom_range(2, 126);
    for (int i = 0; i < 6; i++) begin
      p = rand_pt();
      q = pmul(p, ks[i]);
      ref_search(p, q, ef, ek);
      run_search(p, q, cyc);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rt_done k=%0d got %b want 1", ks[i], done); end
      checks++; if (found !== ef)  begin errors++; $display("FAIL rt_found k=%0d got %b want %b", ks[i], found, ef); end
      checks++; if (scalar !== 7'(ek)) begin
        errors++; $display("FAIL rt_scalar k=%0d got %0d want %0d", ks[i], scalar, ek);
      end
      checks++; if (cyc != exp_cycles(p, ek)) begin
        errors++; $display("FAIL rt_cycles k=%0d got %0d want %0d", ks[i], cyc, exp_cycles(p, ek));
      end
    end
  endtask

  task automatic test_not_member();
    int cyc, ek;
    bit ef, got;
    logic [13:0] p, q;
    got = 1'b0;
    p = 14'h0; q = 14'h0;
    for (int t = 0; t < 300 && !got; t++) begin
      p = rand_pt();
      q = rand_pt();
      ref_search(p, q, ef, ek);
      if (!ef && p[13:7] != 7'h0) got = 1'b1;
    end
    // The 2-torsion point (0,1): any other target must stop at k=1.
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        p = 14'h0001;
        q = rand_pt();
        while (q == p) q = rand_pt();
      end
      ref_search(p, q, ef, ek);
      run_search(p, q, cyc);
      checks++; if (found !== ef) begin errors++; $display("FAIL nm_found got %b want %b", found, ef); end
      checks++; if (scalar !== 7'(ek)) begin errors++; $display("FAIL nm_scalar got %0d want %0d", scalar, ek); end
      checks++; if (cyc != exp_cycles(p, ek)) begin
        errors++; $display("FAIL nm_cycles got %0d want %0d", cyc, exp_cycles(p, ek));
      end
    end
  endtask

  task automatic test_inf_base();
    int cyc;
    run_search(14'h0, rand_pt(), cyc);
    checks++; if (found !== 1'b0)    begin errors++; $display("FAIL inf_found got %b want 0", found); end
    checks++; if (scalar !== 7'd127) begin errors++; $display("FAIL inf_scalar got %0d want 127", scalar); end
    checks++; if (cyc != 129)        begin errors++; $display("FAIL inf_cycles got %0d want 129", cyc); end
  endtask

  task automatic test_restart();
    int cyc;
    logic [13:0] p, p2;
    p = rand_pt();
    while (p[13:7] == 7'h0) p = rand_pt();
    base = p; target = pmul(p, 2); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b want 1", busy); end
    p2 = rand_pt();
    run_search(p2, p2, cyc);
    checks++; if (found !== 1'b1)  begin errors++; $display("FAIL restart_found got %b want 1", found); end
    checks++; if (scalar !== 7'd1) begin errors++; $display("FAIL restart_scalar got %0d want 1", scalar); end
    checks++; if (cyc != 3)        begin errors++; $display("FAIL restart_cycles got %0d want 3", cyc); end
  endtask

  task automatic test_reset_mid();
    logic [13:0] p;
    p = rand_pt();
    while (p[13:7] == 7'h0) p = rand_pt();
    base = p; target = pmul(p, 2); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL midrst_done got %b want 0", done); end
    checks++; if (scalar !== 7'd0) begin errors++; $display("FAIL midrst_scalar got %0d want 0", scalar); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int x = 0; x < 128; x++)
      for (int y = 0; y < 128; y++)
        if (on_curve(7'(x), 7'(y))) pts.push_back({7'(x), 7'(y)});
    @(negedge clk);
    test_reset();
    test_zero_target();
    test_self();
    test_round_trip();
    test_not_member();
    test_inf_base();
    test_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
